// File: rtl/rvv_mem_pkg.sv
// rvv_mem_pkg: shared request type, counter width and pointer-width helper for the memory responder
package rvv_mem_pkg;
   localparam int RVV_MEM_CNT_W = 32;
   localparam int RVV_MEM_DW    = 64;
   localparam int RVV_MEM_AW    = 5;
   typedef struct packed {
      logic                  we;
      logic [RVV_MEM_AW-1:0] addr;
      logic [RVV_MEM_DW-1:0] wdata;
   } mem_req_t;
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/rvv_rsp_fifo.sv
// rvv_rsp_fifo: circular response FIFO, power-of-two depth, pointers wrap naturally
module rvv_rsp_fifo
   import rvv_mem_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        head,
   output logic [ptr_w(DEPTH):0]   count
);
   localparam int PW = ptr_w(DEPTH);
   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wp, rp;
   // data storage needs no reset: the head is only observed while count is non-zero
   always_ff @(posedge clk) begin
      if (push) store[wp] <= din;
   end
   // pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + PW'(push);
         rp    <= rp + PW'(pop);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   assign head = store[rp];
endmodule

// File: rtl/rvv_mem_responder.sv
// rvv_mem_responder: flop memory with in-order, credit-protected read responses; RVV_MEM_STATS_EN adds request counters
module rvv_mem_responder
   import rvv_mem_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 5,
   parameter int RSP_DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid_in,
   input  logic                      req_we_in,
   input  logic [MEM_ADDR_WIDTH-1:0] req_addr_in,
   input  logic [DATA_WIDTH-1:0]     req_wdata_in,
   output logic                      req_ready_out,
   output logic [DATA_WIDTH-1:0]     rsp_data_out,
   output logic                      rsp_valid_out,
   input  logic                      rsp_ready_in
`ifdef RVV_MEM_STATS_EN
   ,
   output logic [RVV_MEM_CNT_W-1:0]  rd_count_out,
   output logic [RVV_MEM_CNT_W-1:0]  wr_count_out
`endif
);
   localparam int PW = ptr_w(RSP_DEPTH);
   logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_q, head;
   logic                  rd_pend;
   logic [PW:0]           fifo_cnt;
   logic                  fifo_empty, fire, rd_fire, wr_fire, pop, fifo_push, fifo_pop;
   mem_req_t              req;
   assign req           = '{we: req_we_in, addr: req_addr_in, wdata: req_wdata_in};
   assign fire          = req_valid_in & req_ready_out;
   assign rd_fire       = fire & ~req.we;
   assign wr_fire       = fire & req.we;
   assign fifo_empty    = fifo_cnt == '0;
   assign req_ready_out = 32'(fifo_cnt) + 32'(rd_pend) < 32'(RSP_DEPTH);
   // a pending read is presented directly when the FIFO is empty, giving one-cycle latency
   assign rsp_valid_out = ~fifo_empty | rd_pend;
   assign rsp_data_out  = fifo_empty ? rd_q : head;
   assign pop           = rsp_valid_out & rsp_ready_in;
   assign fifo_pop      = pop & ~fifo_empty;
   assign fifo_push     = rd_pend & ~(pop & fifo_empty);
   // word store, cleared in full by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**MEM_ADDR_WIDTH; i++) mem[i] <= '0;
      end else if (wr_fire) begin
         mem[req.addr] <= req.wdata;
      end
   end
   // read pipeline stage ahead of the response FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= rd_fire;
         if (rd_fire) rd_q <= mem[req.addr];
      end
   end
   rvv_rsp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rd_q),
      .head  (head),
      .count (fifo_cnt)
   );
`ifdef RVV_MEM_STATS_EN
   logic [RVV_MEM_CNT_W-1:0] rd_cnt, wr_cnt;
   // accepted-request counters, wrapping at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         rd_cnt <= rd_cnt + RVV_MEM_CNT_W'(rd_fire);
         wr_cnt <= wr_cnt + RVV_MEM_CNT_W'(wr_fire);
      end
   end
   assign rd_count_out = rd_cnt;
   assign wr_count_out = wr_cnt;
`endif
endmodule

// File: tb/tb_rvv_mem_responder.sv
// tb_rvv_mem_responder: randomized and directed checks against an in-order response queue model
module tb_rvv_mem_responder;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int D  = 4;
   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid_in, req_we_in, req_ready_out, rsp_valid_out, rsp_ready_in;
   logic [AW-1:0] req_addr_in;
   logic [DW-1:0] req_wdata_in, rsp_data_out;
`ifdef RVV_MEM_STATS_EN
   logic [31:0]   rd_count_out, wr_count_out;
`endif
   logic [DW-1:0] mmem [2**AW];
   logic [DW-1:0] q [$];
   int            n_chk = 0;
   int            n_pass = 0;
   always #5 clk = ~clk;
   rvv_mem_responder #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .RSP_DEPTH(D)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_in  (req_valid_in),
      .req_we_in     (req_we_in),
      .req_addr_in   (req_addr_in),
      .req_wdata_in  (req_wdata_in),
      .req_ready_out (req_ready_out),
      .rsp_data_out  (rsp_data_out),
      .rsp_valid_out (rsp_valid_out),
      .rsp_ready_in  (rsp_ready_in)
`ifdef RVV_MEM_STATS_EN
      ,
      .rd_count_out  (rd_count_out),
      .wr_count_out  (wr_count_out)
`endif
   );
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   // Model: every accepted read is an outstanding response until popped; at most D outstanding.
   task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
      logic fire, pop;
      chk("ready", req_ready_out, (q.size() < D));
      chk("valid", rsp_valid_out, (q.size() > 0));
      if (q.size() > 0) chk("data", rsp_data_out, q[0]);
      req_valid_in = v; req_we_in = we; req_addr_in = a; req_wdata_in = d; rsp_ready_in = rr;
      fire = v && (q.size() < D);
      pop  = rr && (q.size() > 0);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (fire) begin
         if (we) mmem[a] = d;
         else q.push_back(mmem[a]);
      end
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, '0, '0, 1'b1);
   endtask
   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
   endtask
   always @(negedge clk) begin
      if (!rst) chk("fifo_no_overflow", (dut.fifo_push && dut.fifo_cnt == D), 1'b0);
   end
   initial begin
      int acc, guard;
      logic now_rdy;
      rst = 1'b1;
      req_valid_in = 0; req_we_in = 0; req_addr_in = '0; req_wdata_in = '0; rsp_ready_in = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready_out, 1'b1);
      chk("rst_valid", rsp_valid_out, 1'b0);
      chk("rst_data", rsp_data_out, '0);
      rst = 1'b0;
      cycle(1'b1, 1'b0, 5'd3, '0, 1'b1);
      chk("t1_valid", rsp_valid_out, 1'b1);
      chk("t1_data", rsp_data_out, '0);
      idle(2);
      cycle(1'b1, 1'b1, 5'd7, 64'hDEADBEEF_CAFEF00D, 1'b1);
      cycle(1'b1, 1'b0, 5'd7, '0, 1'b1);
      chk("t2_valid", rsp_valid_out, 1'b1);
      chk("t2_data", rsp_data_out, 64'hDEADBEEF_CAFEF00D);
      idle(2);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, AW'(i), DW'(i), 1'b1);
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         if (req_ready_out) acc++;
         cycle(1'b1, 1'b0, AW'(i), '0, 1'b0);
      end
      chk("t3_accepted", DW'(acc), DW'(4));
      chk("t3_ready_low", req_ready_out, 1'b0);
      chk("t3_head_hold", rsp_data_out, '0);
      guard = 0;
      for (int i = 4; i < 6 && guard < 20; guard++) begin
         now_rdy = req_ready_out;
         cycle(1'b1, 1'b0, AW'(i), '0, 1'b1);
         if (now_rdy) i++;
      end
      chk("t3_reissue_done", DW'(guard < 20), DW'(1));
      idle(6);
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
               {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      idle(6);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, AW'($urandom), '0, 1'b0);
      idle(0);
      cycle(1'b0, 1'b0, '0, '0, 1'b0);
      chk("t4_fill", DW'(dut.u_fifo.count), DW'(3));
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b0, AW'($urandom), '0, 1'b1);
         chk("t4_count", DW'(dut.u_fifo.count), DW'(2));
      end
      idle(6);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, AW'(i + 8), '0, 1'b0);
      chk("t5_pre_count", DW'(dut.u_fifo.count), DW'(3));
      chk("t5_pre_pend", DW'(dut.rd_pend), DW'(1));
      #2 rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("t5_valid", rsp_valid_out, 1'b0);
      chk("t5_ready", req_ready_out, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, AW'(i * 3 + 1), '0, 1'b1);
      idle(3);
      for (int i = 0; i < 200; i++)
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, AW'($urandom),
               {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      idle(6);
`ifdef RVV_MEM_STATS_EN
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, AW'(i), {$urandom, $urandom}, 1'b1);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b1);
      idle(2);
      chk("stat_wr", DW'(wr_count_out), DW'(5));
      chk("stat_rd", DW'(rd_count_out), DW'(9));
      force dut.rd_cnt = 32'hFFFF_FFFF;
      #1 release dut.rd_cnt;
      cycle(1'b1, 1'b0, 5'd2, '0, 1'b1);
      chk("stat_wrap", DW'(rd_count_out), DW'(0));
      idle(2);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rvv_mem_responder.md
# rvv_mem_responder

Memory-side responder for the vector processor's memory port. It accepts read and write requests from `rvv_proc_main`, holds a flop-based store of `2**MEM_ADDR_WIDTH` words of `DATA_WIDTH` bits, and returns read data in request order through a credit-protected response FIFO. The response FIFO honours the processor's ready signal. It sits beside `rvv_proc_main` at the top level and is the far end of its `mem_port_*` signals.

## Interface
- `DATA_WIDTH`, 64: word width in bits.
- `MEM_ADDR_WIDTH`, 5: word address width; depth = `2**MEM_ADDR_WIDTH`.
- `RSP_DEPTH`, 4: response FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid_in` in 1: request valid (driven by processor `mem_port_valid_out`).
- `req_we_in` in 1: 1 = write, 0 = read.
- `req_addr_in` in `MEM_ADDR_WIDTH`: word address (processor `mem_port_addr_out`).
- `req_wdata_in` in `DATA_WIDTH`: write data (processor `mem_port_out`).
- `req_ready_out` out 1: request accepted when high together with `req_valid_in`.
- `rsp_data_out` out `DATA_WIDTH`: read data (to processor `mem_port_in`).
- `rsp_valid_out` out 1: response valid (to processor `mem_port_valid_in`).
- `rsp_ready_in` in 1: processor accepts the response (processor `mem_port_ready_out`).
- `rd_count_out`, `wr_count_out` out 32 each: accepted-request counters. These ports exist only with `RVV_MEM_STATS_EN`.

## Operation
- Handshake: a request fires when `req_valid_in & req_ready_out`. A response pops when `rsp_valid_out & rsp_ready_in`.
- Write fire: `mem[req_addr_in] <= req_wdata_in` at the edge. No response is generated.
- Read fire: `mem[req_addr_in]` is captured into pipeline register `rd_q`, and `rd_pend` is set. On the next edge `rd_q` is pushed into the FIFO.
- Credit: `req_ready_out = (fifo_count + rd_pend) < RSP_DEPTH`.
  - Computed from registers only; there is no combinational path from `rsp_ready_in` or `req_valid_in`.
  - Writes are gated by the same credit, so a stalled read response backpressures all traffic.
- FIFO behaviour:
  - Circular, with `log2(RSP_DEPTH)`-bit read and write pointers that wrap modulo `RSP_DEPTH`.
  - `fifo_count` is 0..`RSP_DEPTH`.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop on an empty FIFO is impossible because valid is low.
  - A push into a full FIFO is impossible by credit; the bench asserts on it.
- Ordering: responses return in read-request order.
- Read after write, same address, in consecutive fires: the read returns the new data.
- Reset: asserting `rst` at any time, including mid-transfer, immediately does the following.
  - Clears every memory word to 0.
  - Clears the FIFO pointers and count, `rd_pend`, and both counters.
  - Any in-flight reads are dropped.

## Timing
- Reset values: `req_ready_out`=1, `rsp_valid_out`=0, `rsp_data_out`=0, counters=0.
- Read fire in cycle N: data is in the FIFO after edge N+1. `rsp_valid_out`=1 in cycle N+1 if the FIFO was empty, so read latency is 1 cycle.
- `rsp_data_out` = FIFO head, valid whenever `rsp_valid_out`=1. It holds stable while `rsp_ready_in`=0.
- Sustained throughput with `rsp_ready_in` held high: one read per cycle.
- With `rsp_ready_in` held low: at most `RSP_DEPTH` reads are accepted, then `req_ready_out` drops in the cycle after the last credit is consumed.
- A pop in cycle M returns one credit. `req_ready_out` reflects it in cycle M+1.

## Configuration
- `RVV_MEM_STATS_EN` defined:
  - `rd_count_out` increments on each read fire; `wr_count_out` increments on each write fire.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `RVV_MEM_STATS_EN` undefined: the counters and their ports are absent. Other behaviour is identical.

## Structure
- Shared package `rvv_mem_pkg`:
  - `mem_req_t` struct (`we`, `addr`, `wdata`).
  - Constant `RVV_MEM_CNT_W` = 32.
  - `clog2`-derived pointer width function.
- One sub-module, `rvv_rsp_fifo`: parameterised circular FIFO (`WIDTH`, `DEPTH`) exposing `count`, `push`, `pop`, `head`. The storage array, `rd_q`/`rd_pend` and the credit logic stay in the top module.

## Test plan
- Reset, then read addr 3 → `rsp_valid_out` is 1 one cycle after the fire, with data 0.
- Write 0xDEADBEEF_CAFEF00D to addr 7, then read addr 7 in the next cycle → response 0xDEADBEEF_CAFEF00D, latency 1.
- `rsp_ready_in`=0 and 6 back-to-back reads to addrs 0..5 (preloaded with value = addr) → only 4 accepted and `req_ready_out` falls. Then raise `rsp_ready_in` → responses 0,1,2,3 in order, and the remaining reads complete as 4,5.
- Simultaneous push and pop with the FIFO at count 2 for 20 cycles of random reads → count stays 2, no loss, pointers wrap correctly.
- Assert `rst` while the FIFO holds 3 entries and a read is pending → next cycle `rsp_valid_out`=0, `req_ready_out`=1, and all memory reads return 0.
- With `RVV_MEM_STATS_EN`: 5 writes and 9 reads → `wr_count_out`=5, `rd_count_out`=9. Force the counter to 0xFFFFFFFF, fire one read → `rd_count_out`=0.
